// File: rtl/my_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// my_alu_seq_pkg
// Shared definitions for the sequential ALU: width constants, operation
// encodings, FSM state encodings and a small helper that says whether an
// operation needs the multi-cycle iteration datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package my_alu_seq_pkg;

  localparam int OPW  = 3;   // opcode width
  localparam int DW   = 8;   // operand width
  localparam int RW   = 9;   // result width
  localparam int ITER = 8;   // iterations for mul/div/rest

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_REST = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Division-family opcodes share the restoring datapath.
  function automatic logic is_div_op(input logic [OPW-1:0] op);
    return (op == OP_DIV) || (op == OP_REST);
  endfunction

  // mul always iterates; div/rest iterate only with a non-zero divisor,
  // a zero divisor is resolved immediately as an error.
  function automatic logic is_iterative(input logic [OPW-1:0] op,
                                        input logic [DW-1:0]  b);
    return (op == OP_MUL) || (is_div_op(op) && (b != '0));
  endfunction

endpackage

// File: rtl/my_alu_seq_iter.sv
// -----------------------------------------------------------------------------
// my_alu_iter
// One-bit-per-cycle iteration datapath shared by multiply (shift-add, LSB
// first) and divide/remainder (restoring division, MSB first).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             initialise registers from a/b (accepting edge)
//   step             perform one iteration
//   div_mode         1 = restoring division, 0 = shift-add multiply
//   a, b             raw operands, used only when load=1
//   product_next     16-bit partial product after the current step
//   quotient_next    quotient register after the current step
//   remainder_next   remainder after the current step
// The *_next outputs are the register values the current step will write,
// so the owner can capture the final answer on the last iteration edge.
// -----------------------------------------------------------------------------
module my_alu_iter
  import my_alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] product_next,
  output logic [DW-1:0]   quotient_next,
  output logic [DW-1:0]   remainder_next
);

  // acc_reg : partial product (mul) or partial remainder (div)
  // opnd_reg: shifting multiplicand (mul) or divisor in low byte (div)
  // sh_reg  : multiplier shifting right (mul) or dividend/quotient (div)
  logic [2*DW-1:0] acc_reg,  acc_next;
  logic [2*DW-1:0] opnd_reg, opnd_next;
  logic [DW-1:0]   sh_reg,   sh_next;

  logic [DW:0]     rem_shift;
  logic [DW+1:0]   rem_diff;
  logic [DW:0]     rem_new;
  logic            q_bit;

  always_comb begin
    acc_next  = acc_reg;
    opnd_next = opnd_reg;
    sh_next   = sh_reg;
    rem_shift = {acc_reg[DW-1:0], sh_reg[DW-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_reg[DW-1:0]};
    q_bit     = ~rem_diff[DW+1];
    rem_new   = q_bit ? rem_diff[DW:0] : rem_shift;
    if (div_mode) begin
      // Bring in the next dividend bit, subtract if it fits, and shift the
      // quotient bit into the vacated LSB of the dividend register.
      acc_next = {{(DW-1){1'b0}}, rem_new};
      sh_next  = {sh_reg[DW-2:0], q_bit};
    end else begin
      acc_next  = sh_reg[0] ? (acc_reg + opnd_reg) : acc_reg;
      opnd_next = {opnd_reg[2*DW-2:0], 1'b0};
      sh_next   = {1'b0, sh_reg[DW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      opnd_reg <= '0;
      sh_reg   <= '0;
    end else if (load) begin
      acc_reg  <= '0;
      opnd_reg <= {{DW{1'b0}}, (div_mode ? b : a)};
      sh_reg   <= div_mode ? a : b;
    end else if (step) begin
      acc_reg  <= acc_next;
      opnd_reg <= opnd_next;
      sh_reg   <= sh_next;
    end
  end

  assign product_next   = acc_next;
  assign quotient_next  = sh_next;
  assign remainder_next = acc_next[DW-1:0];

endmodule

// File: rtl/my_alu_seq.sv
// -----------------------------------------------------------------------------
// my_alu_seq
// Sequential 8-bit ALU: add, sub, mul, div, rest. add/sub/errors finish one
// edge after accept; mul/div/rest iterate for 8 edges in my_alu_iter.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   op      0 add, 1 sub, 2 mul, 3 div, 4 rest, 5-7 invalid
//   a, b    8-bit unsigned operands
//   busy    high in CALC and DONE
//   done    one-cycle completion pulse (DONE state)
//   result  9-bit registered result
//   ovf     mul product did not fit in 9 bits
//   err     divide by zero or invalid op
// -----------------------------------------------------------------------------
module my_alu_seq
  import my_alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic           busy,
  output logic           done,
  output logic [RW-1:0]  result,
  output logic           ovf,
  output logic           err
);

  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  state_t          state_reg;
  logic [2:0]      cnt_reg;
  logic [OPW-1:0]  op_reg;
  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   b_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [RW-1:0]   result_reg;
  logic            ovf_reg;
  logic            err_reg;

  logic            accept;
  logic            iter_run;
  logic            iter_step;
  logic            iter_div;
  logic [2*DW-1:0] prod_next;
  logic [DW-1:0]   quot_next;
  logic [DW-1:0]   rem_next;

  logic [RW-1:0]   fin_result;
  logic            fin_ovf;
  logic            fin_err;

  assign accept    = (state_reg == ST_IDLE) && start;
  assign iter_run  = is_iterative(op_reg, b_reg);
  assign iter_step = (state_reg == ST_CALC) && iter_run;
  // On the accepting edge the captured opcode is not yet registered, so the
  // datapath mode comes straight from the op input.
  assign iter_div  = accept ? is_div_op(op) : is_div_op(op_reg);

  my_alu_iter u_iter (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (accept),
    .step           (iter_step),
    .div_mode       (iter_div),
    .a              (a),
    .b              (b),
    .product_next   (prod_next),
    .quotient_next  (quot_next),
    .remainder_next (rem_next)
  );

  // Final values written on the edge entering DONE. For iterative ops this is
  // the last step edge, hence the use of the datapath's *_next outputs.
  always_comb begin
    fin_result = '0;
    fin_ovf    = 1'b0;
    fin_err    = 1'b0;
    case (op_t'(op_reg))
      OP_ADD: fin_result = {1'b0, a_reg} + {1'b0, b_reg};
      OP_SUB: fin_result = {1'b0, a_reg} - {1'b0, b_reg};
      OP_MUL: begin
        fin_result = prod_next[RW-1:0];
        fin_ovf    = |prod_next[2*DW-1:RW];
      end
      OP_DIV: begin
        if (b_reg == '0) begin
          fin_result = '1;
          fin_err    = 1'b1;
        end else begin
          fin_result = {1'b0, quot_next};
        end
      end
      OP_REST: begin
        if (b_reg == '0) begin
          fin_result = {1'b0, a_reg};
          fin_err    = 1'b1;
        end else begin
          fin_result = {1'b0, rem_next};
        end
      end
      default: fin_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            op_reg    <= op;
            a_reg     <= a;
            b_reg     <= b;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (iter_run) begin
            cnt_reg <= cnt_reg + 3'd1;  // wraps 7 -> 0 on the last step
          end
          if (!iter_run || (cnt_reg == CNT_LAST)) begin
            result_reg <= fin_result;
            ovf_reg    <= fin_ovf;
            err_reg    <= fin_err;
            done_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_my_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_my_alu_seq
// Directed and randomized checks of my_alu_seq against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_my_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [8:0] result;
  logic       ovf;
  logic       err;

  int checks = 0;
  int errors = 0;

  my_alu_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input int exp);
    checks++;
    assert (got === 16'(exp))
    else begin
      errors++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic void model(input int o, input int ia, input int ib,
                                output int res, output int e_ovf,
                                output int e_err, output int lat);
    int p;
    res = 0; e_ovf = 0; e_err = 0; lat = 1;
    case (o)
      0: res = (ia + ib) % 512;
      1: res = (ia - ib + 512) % 512;
      2: begin
        p = ia * ib;
        res = p % 512;
        e_ovf = (p > 511) ? 1 : 0;
        lat = 8;
      end
      3: if (ib == 0) begin res = 511; e_err = 1; end
         else begin res = ia / ib; lat = 8; end
      4: if (ib == 0) begin res = ia; e_err = 1; end
         else begin res = ia % ib; lat = 8; end
      default: e_err = 1;
    endcase
  endfunction

  // One complete transaction. With perturb set, start/op/a/b are scrambled
  // every cycle while the block is busy.
  task automatic run_op(input int o, input int ia, input int ib, input bit perturb);
    int e_res, e_ovf, e_err, lat, n;
    model(o, ia, ib, e_res, e_ovf, e_err, lat);
    @(negedge clk);
    start = 1'b1; op = 3'(o); a = 8'(ia); b = 8'(ib);
    @(posedge clk); #1;
    check("accept_busy", {15'd0, busy}, 1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      if (perturb) begin
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 16'(n), lat);
    check("result", {7'd0, result}, e_res);
    check("ovf", {15'd0, ovf}, e_ovf);
    check("err", {15'd0, err}, e_err);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", {15'd0, done}, 0);
    check("idle_busy", {15'd0, busy}, 0);
    check("result_hold", {7'd0, result}, e_res);
    $display("op=%0d a=%0d b=%0d -> result=%0d ovf=%0d err=%0d latency=%0d",
             o, ia, ib, result, ovf, err, n);
  endtask

  initial begin
    int ra, rb, ro;
    rst_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'd0, busy}, 0);
    check("rst_done", {15'd0, done}, 0);
    check("rst_result", {7'd0, result}, 0);
    check("rst_ovf", {15'd0, ovf}, 0);
    check("rst_err", {15'd0, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(0, 25, 3, 1'b0);
    run_op(1, 25, 3, 1'b0);
    run_op(1, 3, 25, 1'b0);
    run_op(2, 25, 3, 1'b0);
    run_op(2, 200, 3, 1'b0);
    run_op(3, 25, 3, 1'b0);
    run_op(4, 25, 3, 1'b0);
    run_op(3, 25, 0, 1'b0);
    run_op(4, 25, 0, 1'b0);
    run_op(6, 25, 3, 1'b0);
    run_op(2, 255, 255, 1'b0);
    run_op(3, 255, 1, 1'b0);
    // start pulsed with new operands during mul CALC
    run_op(2, 25, 3, 1'b1);
    check("no_queued_accept", {15'd0, busy}, 0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'd10; b = 8'd20;
    @(posedge clk); #1;
    check("b2b_accept1", {15'd0, busy}, 1);
    @(posedge clk); #1;
    check("b2b_done1", {15'd0, done}, 1);
    check("b2b_result1", {7'd0, result}, 30);
    @(negedge clk);
    op = 3'd1; a = 8'd50; b = 8'd8;
    @(posedge clk); #1;
    check("b2b_idle", {15'd0, busy}, 0);
    @(posedge clk); #1;
    check("b2b_accept2", {15'd0, busy}, 1);
    @(posedge clk); #1;
    check("b2b_done2", {15'd0, done}, 1);
    check("b2b_result2", {7'd0, result}, 42);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    $display("back-to-back add 10+20 then sub 50-8 -> result=%0d", result);

    // Reset during iteration 4 of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 8'd25; b = 8'd3;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {15'd0, busy}, 0);
    check("abort_done", {15'd0, done}, 0);
    check("abort_result", {7'd0, result}, 0);
    check("abort_err", {15'd0, err}, 0);
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_done", {15'd0, done}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-divide: outputs cleared, no done pulse");
    run_op(0, 25, 3, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = $urandom_range(0, 7);
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
